// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional checksum trailer is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0040_0000;
  localparam int          LEN_W             = 16;

  // Byte address of word idx, wrapping modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0]      base,
                                            input logic [LEN_W-1:0] idx);
    return base + {{(32-LEN_W-2){1'b0}}, idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte assembler: four pushes build one 32-bit word, first byte in [7:0].
// o_full flags the push that completes a word; o_word_nxt already includes the current byte.
module byte_packer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_push,
  input  logic [7:0]  i_byte,
  output logic [1:0]  o_cnt,
  output logic        o_full,
  output logic [31:0] o_word_nxt
);

  logic [1:0]  r_cnt;
  logic [23:0] r_word;

  assign o_word_nxt = {i_byte, r_word};
  assign o_full     = i_push && (r_cnt == 2'd3);
  assign o_cnt      = r_cnt;

  // Only the three most recent bytes need storage; the fourth arrives with the push.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_push) begin
      r_cnt  <= r_cnt + 2'd1;
      r_word <= o_word_nxt[31:8];
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader writing 32-bit words into instruction RAM.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing 32-bit sum of all words.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte_data,
  output logic        o_byte_ready,
  output logic        o_we,
  output logic [31:0] o_wa,
  output logic [31:0] o_wd,
  output logic        o_cpu_hold,
  output logic        o_done,
  output logic        o_err,
  output state_t      o_state
);

  // Byte handshake: a byte moves on a rising edge where i_byte_valid && o_byte_ready;
  // o_byte_ready is a registered decode of the state, high only in LEN, DATA and CHK.
  state_t           r_state;
  logic             r_byte_ready;
  logic             r_we;
  logic [31:0]      r_wa;
  logic [31:0]      r_wd;
  logic             r_cpu_hold;
  logic             r_done;
  logic             r_err;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_idx;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]      r_sum;
`endif

  state_t           w_next;
  logic             w_xfer;
  logic             w_clr;
  logic             w_full;
  logic [1:0]       w_cnt;
  logic [31:0]      w_word_nxt;
  logic [LEN_W-1:0] w_len;
  logic             w_len_bad;
  logic             w_len_last;
  logic [LEN_W-1:0] w_idx_inc;

  assign w_xfer     = i_byte_valid && r_byte_ready;
  assign w_len      = w_word_nxt[31:16];
  assign w_len_bad  = (w_len == '0) || (int'(w_len) > MAX_WORDS);
  assign w_len_last = (r_state == ST_LEN) && w_xfer && (w_cnt == 2'd1);
  assign w_idx_inc  = r_idx + LEN_W'(1);
  // The packer restarts whenever a session enters or leaves the length phase.
  assign w_clr      = (r_state == ST_LEN) != (w_next == ST_LEN);

  byte_packer u_packer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (w_clr),
    .i_push     (w_xfer),
    .i_byte     (i_byte_data),
    .o_cnt      (w_cnt),
    .o_full     (w_full),
    .o_word_nxt (w_word_nxt)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_next = ST_LEN;
      ST_LEN:   if (w_len_last) w_next = w_len_bad ? ST_ERR : ST_DATA;
      ST_DATA:  if (w_full) w_next = ST_WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_WRITE: w_next = (w_idx_inc == r_len) ? ST_CHK : ST_DATA;
      ST_CHK:   if (w_full) w_next = (w_word_nxt == r_sum) ? ST_DONE : ST_ERR;
`else
      ST_WRITE: w_next = (w_idx_inc == r_len) ? ST_DONE : ST_DATA;
`endif
      ST_DONE,
      ST_ERR:   if (i_start) w_next = ST_LEN;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_byte_ready <= 1'b0;
      r_we         <= 1'b0;
      r_wa         <= BASE_ADDR;
      r_wd         <= '0;
      r_cpu_hold   <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_len        <= '0;
      r_idx        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum        <= '0;
`endif
    end else begin
      r_state      <= w_next;
      r_byte_ready <= w_next inside {ST_LEN, ST_DATA, ST_CHK};
      r_we         <= (w_next == ST_WRITE);
      r_cpu_hold   <= w_next inside {ST_LEN, ST_DATA, ST_WRITE, ST_CHK, ST_ERR};
      r_done       <= (w_next == ST_DONE);
      r_err        <= (w_next == ST_ERR);
      if (r_state != ST_LEN && w_next == ST_LEN) begin
        r_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_sum <= '0;
`endif
      end
      if (w_len_last) r_len <= w_len;
      // Address and data are launched with the write so they are stable for the whole strobe.
      if (w_next == ST_WRITE) begin
        r_wa <= word_addr(BASE_ADDR, r_idx);
        r_wd <= w_word_nxt;
      end
      if (r_state == ST_WRITE) begin
        r_idx <= w_idx_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_sum <= r_sum + r_wd;
`endif
      end
    end
  end

  assign o_byte_ready = r_byte_ready;
  assign o_we         = r_we;
  assign o_wa         = r_wa;
  assign o_wd         = r_wd;
  assign o_cpu_hold   = r_cpu_hold;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_state      = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: fixed sequences, a length table and random sessions.
// Builds with or without IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam int          MAXW = 1024;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_byte_valid = 1'b0;
  logic [7:0]  i_byte_data = '0;
  logic        o_byte_ready, o_we, o_cpu_hold, o_done, o_err;
  logic [31:0] o_wa, o_wd;
  state_t      o_state;

  always #5 i_clk = ~i_clk;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_byte_valid(i_byte_valid), .i_byte_data(i_byte_data),
    .o_byte_ready(o_byte_ready), .o_we(o_we), .o_wa(o_wa), .o_wd(o_wd),
    .o_cpu_hold(o_cpu_hold), .o_done(o_done), .o_err(o_err), .o_state(o_state)
  );

  int          n_tests = 0;
  int          n_fail = 0;
  int          n_writes = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  stim_q[$];
  logic [63:0] mon_exp;

  typedef struct {
    logic [15:0] n;
    logic        exp_err;
    int          exp_words;
  } len_vec_t;
  len_vec_t tbl[6];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the head of the expected queue.
  always @(negedge i_clk) begin
    if (!i_rst && o_we) begin
      n_writes++;
      check("ready_low_in_write", 64'(o_byte_ready), 64'd0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: wa=%h wd=%h with none expected", o_wa, o_wd);
      end else begin
        mon_exp = exp_q.pop_front();
        check("write", {o_wa, o_wd}, mon_exp);
      end
    end
  end

  task automatic reset_check(input string nm);
    @(posedge i_clk);
    #3;
    i_rst = 1'b1;
    i_start = 1'b0;
    i_byte_valid = 1'b0;
    #1;
    check({nm, "_ready"}, 64'(o_byte_ready), 64'd0);
    check({nm, "_we"},    64'(o_we),         64'd0);
    check({nm, "_wa"},    64'(o_wa),         64'(BASE));
    check({nm, "_wd"},    64'(o_wd),         64'd0);
    check({nm, "_hold"},  64'(o_cpu_hold),   64'd0);
    check({nm, "_done"},  64'(o_done),       64'd0);
    check({nm, "_err"},   64'(o_err),        64'd0);
    check({nm, "_state"}, 64'(o_state),      64'(ST_IDLE));
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  // Offer one byte after gap idle cycles; returns on the negedge after it was taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    i_byte_valid = 1'b0;
    repeat (gap) @(negedge i_clk);
    i_byte_valid = 1'b1;
    i_byte_data = b;
    k = 0;
    while (!o_byte_ready && k < 100) begin
      @(negedge i_clk);
      k++;
    end
    if (k >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL byte_timeout: ready=%0d after %0d cycles, required 1", o_byte_ready, k);
    end
    @(negedge i_clk);
    i_byte_valid = 1'b0;
  endtask

  task automatic wait_end();
    int k;
    k = 0;
    while (!(o_done || o_err) && k < 100) begin
      @(negedge i_clk);
      k++;
    end
    if (k >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL session_timeout: done=%0d err=%0d, required one of them", o_done, o_err);
    end
  endtask

  // Reference model: interprets stim_q as a whole session and predicts writes and outcome.
  task automatic model_stim(output logic ed, output logic ee);
    int          n;
    logic [31:0] w, s;
    n = int'({stim_q[1], stim_q[0]});
    if (n == 0 || n > MAXW) begin
      ed = 1'b0;
      ee = 1'b1;
      return;
    end
    s = '0;
    for (int k = 0; k < n; k++) begin
      w = {stim_q[2+4*k+3], stim_q[2+4*k+2], stim_q[2+4*k+1], stim_q[2+4*k]};
      exp_q.push_back({BASE + 32'(4 * k), w});
      s = s + w;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    w = {stim_q[2+4*n+3], stim_q[2+4*n+2], stim_q[2+4*n+1], stim_q[2+4*n]};
    ed = (w == s);
    ee = !ed;
`else
    ed = 1'b1;
    ee = 1'b0;
`endif
  endtask

  task automatic run_body(input string nm, input int max_gap, input logic ed, input logic ee);
    start_pulse();
    for (int i = 0; i < stim_q.size(); i++) send_byte(stim_q[i], $urandom_range(0, max_gap));
    wait_end();
    check({nm, "_done"},   64'(o_done),       64'(ed));
    check({nm, "_err"},    64'(o_err),        64'(ee));
    check({nm, "_hold"},   64'(o_cpu_hold),   64'(ee));
    check({nm, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_stim(input string nm, input int max_gap);
    logic ed, ee;
    model_stim(ed, ee);
    run_body(nm, max_gap, ed, ee);
  endtask

  task automatic push_bytes32(input logic [31:0] v);
    for (int b = 0; b < 4; b++) stim_q.push_back(v[8*b +: 8]);
  endtask

  task automatic build_load(input logic [15:0] n, input int dwords, input bit good_chk);
    logic [31:0] w, s;
    stim_q.delete();
    stim_q.push_back(n[7:0]);
    stim_q.push_back(n[15:8]);
    s = '0;
    for (int k = 0; k < dwords; k++) begin
      w = $urandom;
      push_bytes32(w);
      s = s + w;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (dwords > 0) push_bytes32(good_chk ? s : (s ^ 32'($urandom_range(1, 255))));
`else
    if (good_chk && dwords < 0) stim_q.delete();
`endif
  endtask

  task automatic load_two_words(input logic [31:0] chk);
    stim_q = '{8'h02, 8'h00, 8'h03, 8'h24, 8'h80, 8'h3E, 8'h83, 8'h24, 8'hC0, 8'h3E};
`ifdef IMEM_LOADER_CHECKSUM_EN
    push_bytes32(chk);
`else
    if (chk == 32'hFFFF_FFFF) stim_q.delete();
`endif
    exp_q.push_back({32'h0040_0000, 32'h3E80_2403});
    exp_q.push_back({32'h0040_0004, 32'h3EC0_2483});
  endtask

  initial begin
    int w0;
    tbl[0] = '{16'd0,    1'b1, 0};
    tbl[1] = '{16'd1025, 1'b1, 0};
    tbl[2] = '{16'hFFFF, 1'b1, 0};
    tbl[3] = '{16'd1,    1'b0, 1};
    tbl[4] = '{16'd3,    1'b0, 3};
    tbl[5] = '{16'd1024, 1'b0, 1024};

    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    reset_check("reset");

    // Two-word load with write timing checked around each fourth byte.
    load_two_words(32'h7D40_4886);
    start_pulse();
    for (int i = 0; i < 10; i++) begin
      send_byte(stim_q[i], 0);
      if (i == 5 || i == 9) begin
        check("we_after_4th", 64'(o_we), 64'd1);
        check("ready_in_write", 64'(o_byte_ready), 64'd0);
        check("wa_in_write", 64'(o_wa), (i == 5) ? 64'h0040_0000 : 64'h0040_0004);
        check("wd_in_write", 64'(o_wd), (i == 5) ? 64'h3E80_2403 : 64'h3EC0_2483);
        check("hold_loading", 64'(o_cpu_hold), 64'd1);
        @(negedge i_clk);
        check("we_one_cycle", 64'(o_we), 64'd0);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    for (int i = 10; i < 14; i++) send_byte(stim_q[i], 0);
`endif
    wait_end();
    check("two_done", 64'(o_done), 64'd1);
    check("two_hold", 64'(o_cpu_hold), 64'd0);
    check("two_err", 64'(o_err), 64'd0);
    check("wa_hold", 64'(o_wa), 64'h0040_0004);
    check("wd_hold", 64'(o_wd), 64'h3EC0_2483);
    check("two_pending", 64'(exp_q.size()), 64'd0);

    load_two_words(32'h7D40_4886);
    run_body("backpressure", 3, 1'b1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    load_two_words(32'h0000_0000);
    w0 = n_writes;
    run_body("bad_chk", 1, 1'b0, 1'b1);
    check("bad_chk_writes", 64'(n_writes - w0), 64'd2);
`endif

    // Reset part-way through the first word must drop it without a write.
    w0 = n_writes;
    stim_q = '{8'h02, 8'h00, 8'h03, 8'h24};
    start_pulse();
    for (int i = 0; i < 4; i++) send_byte(stim_q[i], 0);
    reset_check("mid_reset");
    check("mid_reset_writes", 64'(n_writes - w0), 64'd0);
    load_two_words(32'h7D40_4886);
    run_body("after_reset", 1, 1'b1, 1'b0);

    for (int t = 0; t < 6; t++) begin
      w0 = n_writes;
      build_load(tbl[t].n, tbl[t].exp_err ? 0 : int'(tbl[t].n), 1'b1);
      run_stim("tbl", 0);
      check("tbl_err", 64'(o_err), 64'(tbl[t].exp_err));
      check("tbl_words", 64'(n_writes - w0), 64'(tbl[t].exp_words));
    end

    for (int r = 0; r < 12; r++) begin
      int kind, n;
      kind = $urandom_range(0, 9);
      if (kind == 0) n = 0;
      else if (kind == 1) n = MAXW + 1 + $urandom_range(0, 100);
      else n = $urandom_range(1, 6);
      build_load(16'(n), (kind >= 2) ? n : 0, $urandom_range(0, 3) != 0);
      run_stim("random", 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
